// File: rtl/poly_operand_driver_if.sv
// Operand-load bus between the automatic driver and the polynomial evaluator.
// master = driver side, slave = evaluator/requester side.
interface poly_operand_driver_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] coef_a;
    logic [DATA_W-1:0] coef_b;
    logic [DATA_W-1:0] coef_c;
    logic [DATA_W-1:0] coef_x;
    logic              busy;
    logic              go;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] data_result;
    logic [DATA_W-1:0] result;
    logic              done;
    logic              mismatch;

    modport master (
        input  start, coef_a, coef_b, coef_c, coef_x, data_result,
        output busy, go, data_out, result, done, mismatch
    );

    modport slave (
        output start, coef_a, coef_b, coef_c, coef_x, data_result,
        input  busy, go, data_out, result, done, mismatch
    );
endinterface

// File: rtl/poly_operand_driver.sv
// Serialises operands A, B, C, X onto the evaluator's data_out/go port and captures its result.
// Optional self-check of the evaluator result enabled by defining POLY_CHECK_EN.
module poly_operand_driver #(
    parameter int DATA_W      = 8,
    parameter int GO_HIGH     = 2,
    parameter int GO_LOW      = 2,
    parameter int RESULT_WAIT = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    poly_operand_driver_if.master bus
);
    localparam int MAX_HL  = (GO_HIGH > GO_LOW) ? GO_HIGH : GO_LOW;
    localparam int MAX_CNT = (MAX_HL > RESULT_WAIT) ? MAX_HL : RESULT_WAIT;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(GO_HIGH - 1);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(GO_LOW - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RESULT_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [1:0] LAST_IDX = 2'd3;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DRIVE_HIGH  = 3'd1,
        DRIVE_LOW   = 3'd2,
        WAIT_RESULT = 3'd3,
        DONE        = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [1:0]        idx_r, idx_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [DATA_W-1:0] op_r [4];
    logic              latch_s, capture_s;
    logic              go_r, go_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [DATA_W-1:0] data_r, data_s, next_op_s;
    logic [DATA_W-1:0] result_r;

    // Next-state logic: phase counters, operand index and capture strobe
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        cnt_s     = cnt_r;
        latch_s   = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = DRIVE_HIGH;
                    idx_s   = 2'd0;
                    cnt_s   = CNT_ZERO;
                    latch_s = 1'b1;
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            DRIVE_HIGH: begin
                if (cnt_r == HIGH_LAST) begin
                    state_s = DRIVE_LOW;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            DRIVE_LOW: begin
                if (cnt_r == LOW_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (idx_r == LAST_IDX) begin
                        state_s = WAIT_RESULT;
                    end else begin
                        state_s = DRIVE_HIGH;
                        idx_s   = idx_r + 2'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            WAIT_RESULT: begin
                if (cnt_r == WAIT_LAST) begin
                    state_s   = DONE;
                    cnt_s     = CNT_ZERO;
                    capture_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            DONE: begin
                state_s = IDLE;
                idx_s   = 2'd0;
            end
            default: begin
                state_s = IDLE;
                idx_s   = 2'd0;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output pre-decode from the next state; data_out only loads on a rising go
    always_comb begin
        next_op_s = latch_s ? bus.coef_a : op_r[idx_s];
        go_s      = (state_s == DRIVE_HIGH);
        busy_s    = (state_s != IDLE);
        done_s    = (state_s == DONE);
        if ((state_s == DRIVE_HIGH) && (state_r != DRIVE_HIGH)) begin
            data_s = next_op_s;
        end else if ((state_s == DRIVE_HIGH) || (state_s == DRIVE_LOW)) begin
            data_s = data_r;
        end else begin
            data_s = DATA_ZERO;
        end
    end

    // State, operand latches and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r  <= IDLE;
            idx_r    <= 2'd0;
            cnt_r    <= CNT_ZERO;
            go_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            data_r   <= DATA_ZERO;
            result_r <= DATA_ZERO;
            for (int i = 0; i < 4; i++) begin
                op_r[i] <= DATA_ZERO;
            end
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            go_r    <= go_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            data_r  <= data_s;
            if (capture_s) begin
                result_r <= bus.data_result;
            end else begin
                result_r <= result_r;
            end
            if (latch_s) begin
                op_r[0] <= bus.coef_a;
                op_r[1] <= bus.coef_b;
                op_r[2] <= bus.coef_c;
                op_r[3] <= bus.coef_x;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    op_r[i] <= op_r[i];
                end
            end
        end
    end

    assign bus.go       = go_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.data_out = data_r;
    assign bus.result   = result_r;

`ifdef POLY_CHECK_EN
    logic [DATA_W-1:0] ax_r, bx_r, axx_r, expected_r;
    logic              mismatch_r;

    // Expected value pipeline, one multiply per stage; settles long before capture
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ax_r       <= DATA_ZERO;
            bx_r       <= DATA_ZERO;
            axx_r      <= DATA_ZERO;
            expected_r <= DATA_ZERO;
            mismatch_r <= 1'b0;
        end else begin
            ax_r       <= op_r[0] * op_r[3];
            bx_r       <= op_r[1] * op_r[3];
            axx_r      <= ax_r * op_r[3];
            expected_r <= axx_r + bx_r + op_r[2];
            if (capture_s) begin
                mismatch_r <= (bus.data_result != expected_r);
            end else begin
                mismatch_r <= mismatch_r;
            end
        end
    end

    assign bus.mismatch = mismatch_r;
`else
    assign bus.mismatch = 1'b0;
`endif
endmodule
